// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back write-allocate data cache with miss FSM
module dm_cache_ctrl #(
    parameter  int LINES           = 8,
    parameter  int WORDS_PER_BLOCK = 16,
    localparam int IDX_W           = $clog2(LINES),
    localparam int OFF_W           = $clog2(WORDS_PER_BLOCK),
    localparam int BLK_W           = 32 * WORDS_PER_BLOCK,
    localparam int TAG_W           = 30 - OFF_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [BLK_W-1:0] mem_wdata,
    input  logic [BLK_W-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [31:0]      hit_cnt,
    output logic [31:0]      miss_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_REFILL
    } state_t;

    state_t state, state_nxt;

    logic [29:0]      req_addr;
    logic             req_we;
    logic [31:0]      req_wdata;
    logic             miss_seen;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [BLK_W-1:0] data_arr [LINES];

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [BLK_W-1:0] cur_blk;
    logic [31:0]      cur_word;
    logic             hit;
    logic             unused_addr_bits;

    // Byte-lane bits never matter for word accesses.
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req_off  = req_addr[OFF_W-1:0];
    assign req_idx  = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag  = req_addr[29:OFF_W+IDX_W];
    assign cur_blk  = data_arr[req_idx];
    assign cur_word = cur_blk[{req_off, 5'b0} +: 32];
    assign hit      = valid[req_idx] && (tag_arr[req_idx] == req_tag);

    always_comb begin
        state_nxt = state;
        cpu_ready = 1'b0;
        cpu_rdata = 32'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = '0;
        case (state)
            S_IDLE: begin
                if (cpu_req) state_nxt = S_COMPARE;
            end
            S_COMPARE: begin
                if (hit) begin
                    cpu_ready = 1'b1;
                    if (!req_we) cpu_rdata = cur_word;
                    state_nxt = S_IDLE;
                end else if (valid[req_idx] && dirty[req_idx]) begin
                    state_nxt = S_WRITEBACK;
                end else begin
                    state_nxt = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_arr[req_idx], req_idx, {(OFF_W+2){1'b0}}};
                mem_wdata = cur_blk;
                if (mem_ack) state_nxt = S_REFILL;
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {(OFF_W+2){1'b0}}};
                if (mem_ack) state_nxt = S_COMPARE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            valid     <= '0;
            dirty     <= '0;
            hit_cnt   <= 32'd0;
            miss_cnt  <= 32'd0;
            miss_seen <= 1'b0;
            req_addr  <= 30'd0;
            req_we    <= 1'b0;
            req_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr[31:2];
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        hit_cnt   <= hit_cnt + 32'd1;
                        miss_seen <= 1'b0;
                        if (req_we) dirty[req_idx] <= 1'b1;
                    end else if (!miss_seen) begin
                        // The post-refill COMPARE must not count the same request twice.
                        miss_cnt  <= miss_cnt + 32'd1;
                        miss_seen <= 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (mem_ack) dirty[req_idx] <= 1'b0;
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data contents are meaningless until valid is set, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == S_COMPARE && hit && req_we)
                data_arr[req_idx][{req_off, 5'b0} +: 32] <= req_wdata;
            if (state == S_REFILL && mem_ack) begin
                data_arr[req_idx] <= mem_rdata;
                tag_arr[req_idx]  <= req_tag;
            end
        end
    end

endmodule
